// File: rtl/ram_param.sv
// Parameterised single-port RAM with a clear sweep after reset or clr and
// registered read data. Out-of-range accesses are dropped and flagged on err.
module ram_param #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 128,
  parameter int ADDR_W  = 8,
  parameter bit WR_THRU = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              rw,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                memWe;
  logic [IDX_W-1:0]    memIdx;
  logic [DATA_W-1:0]   memWdata;
  logic                inRange;

  assign inRange = ({1'b0, address} < DEPTH_L);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    memWe      = 1'b0;
    memIdx     = address[IDX_W-1:0];
    memWdata   = data_in;
    unique case (state_q)
      INIT: begin
        if (clr) begin
          ptr_d = '0;
        end else begin
          memWe    = 1'b1;
          memIdx   = ptr_q[IDX_W-1:0];
          memWdata = '0;
          if (ptr_q == LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      IDLE: begin
        // clr wins over a same-cycle request, which is simply dropped
        if (clr) begin
          state_d = INIT;
          ptr_d   = '0;
        end else if (en) begin
          if (!inRange) begin
            err_d = 1'b1;
          end else if (rw) begin
            memWe = 1'b1;
            if (WR_THRU) begin
              data_out_d = data_in;
              rd_valid_d = 1'b1;
            end
          end else begin
            data_out_d = mem[address[IDX_W-1:0]];
            rd_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      ptr_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // The array has no reset; it is zeroed by the INIT sweep instead.
  always_ff @(posedge clk) begin
    if (rst_n && memWe) begin
      mem[memIdx] <= memWdata;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;
  assign busy     = (state_q == INIT);

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: one hold-on-write and one write-through
// instance share the same stimulus and are checked against hand-worked values.
module tb_ram_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rw;
  logic [7:0] address;
  logic [3:0] data_in;
  logic       clr;

  logic [3:0] dataOut0, dataOut1;
  logic       rdValid0, rdValid1;
  logic       busy0, busy1;
  logic       err0, err1;

  int assertCount = 0;
  int failCount   = 0;

  ram_param #(.DATA_W(4), .DEPTH(128), .ADDR_W(8), .WR_THRU(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .rw(rw), .address(address),
    .data_in(data_in), .clr(clr), .data_out(dataOut0), .rd_valid(rdValid0),
    .busy(busy0), .err(err0)
  );

  ram_param #(.DATA_W(4), .DEPTH(128), .ADDR_W(8), .WR_THRU(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .rw(rw), .address(address),
    .data_in(data_in), .clr(clr), .data_out(dataOut1), .rd_valid(rdValid1),
    .busy(busy1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic enI, input logic rwI,
                               input logic [7:0] addrI, input logic [3:0] dataI,
                               input logic clrI);
    en      = enI;
    rw      = rwI;
    address = addrI;
    data_in = dataI;
    clr     = clrI;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until busy drops while hammering a write that must be ignored.
  task automatic waitSweep(input string tag);
    int n;
    int pulses;
    n      = 0;
    pulses = 0;
    applyStimulus(1'b1, 1'b1, 8'd30, 4'hE, 1'b0);
    while (n < 300) begin
      tick();
      n++;
      if (rdValid0 || rdValid1 || err0 || err1) pulses++;
      if (!busy0) break;
    end
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    checkOutput({tag, "_edges"}, n, 128);
    checkOutput({tag, "_pulses"}, pulses, 0);
    checkOutput({tag, "_busy1"}, busy1, 0);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] a,
                           input logic [3:0] expVal);
    applyStimulus(1'b1, 1'b0, a, 4'h0, 1'b0);
    tick();
    checkOutput({tag, "_d0"}, dataOut0, expVal);
    checkOutput({tag, "_d1"}, dataOut1, expVal);
    checkOutput({tag, "_v0"}, rdValid0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    #3;
    checkOutput("rst_data", dataOut0, 0);
    checkOutput("rst_valid", rdValid0, 0);
    checkOutput("rst_err", err0, 0);
    checkOutput("rst_busy", busy0, 1);
    tick();
    tick();
    rst_n = 1'b1;
    waitSweep("init_sweep");

    for (int i = 0; i < 128; i++) begin
      applyStimulus(1'b1, 1'b0, 8'(i), 4'h0, 1'b0);
      tick();
      if (dataOut0 !== 4'h0 || rdValid0 !== 1'b1)
        checkOutput($sformatf("zero_rd_%0d", i), {dataOut0, 3'b0, rdValid0}, 8'h01);
      else
        checkOutput("zero_rd", dataOut0, 0);
    end

    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    tick();
    checkOutput("idle_valid", rdValid0, 0);

    applyStimulus(1'b1, 1'b1, 8'd5, 4'hA, 1'b0);
    tick();
    checkOutput("wr5_v0", rdValid0, 0);
    checkOutput("wr5_d0_hold", dataOut0, 0);
    checkOutput("wr5_v1", rdValid1, 1);
    checkOutput("wr5_d1", dataOut1, 4'hA);
    readCheck("rd5", 8'd5, 4'hA);

    applyStimulus(1'b1, 1'b1, 8'd9, 4'h3, 1'b0);
    tick();
    checkOutput("wr9_d1", dataOut1, 4'h3);
    checkOutput("wr9_v1", rdValid1, 1);
    checkOutput("wr9_d0_hold", dataOut0, 4'hA);
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    tick();
    checkOutput("after_wr_v1", rdValid1, 0);
    checkOutput("after_wr_d1_hold", dataOut1, 4'h3);
    readCheck("rd9", 8'd9, 4'h3);

    applyStimulus(1'b1, 1'b1, 8'd127, 4'h7, 1'b0);
    tick();
    checkOutput("wr127_err", err0, 0);
    readCheck("rd127", 8'd127, 4'h7);

    // Out-of-range accesses: 200 would alias to 72 if the range check were missing.
    readCheck("rd5_again", 8'd5, 4'hA);
    applyStimulus(1'b1, 1'b1, 8'd200, 4'hF, 1'b0);
    tick();
    checkOutput("oor_wr_err", err0, 1);
    checkOutput("oor_wr_err1", err1, 1);
    checkOutput("oor_wr_d0", dataOut0, 4'hA);
    checkOutput("oor_wr_d1", dataOut1, 4'hA);
    checkOutput("oor_wr_v1", rdValid1, 0);
    applyStimulus(1'b1, 1'b0, 8'd128, 4'h0, 1'b0);
    tick();
    checkOutput("oor_rd_err", err0, 1);
    checkOutput("oor_rd_v0", rdValid0, 0);
    checkOutput("oor_rd_d0", dataOut0, 4'hA);
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    tick();
    checkOutput("err_pulse_end", err0, 0);
    readCheck("rd72", 8'd72, 4'h0);
    readCheck("rd5_post_oor", 8'd5, 4'hA);
    readCheck("rd127_post_oor", 8'd127, 4'h7);

    // clr beats a same-cycle write, then the whole array is swept back to zero.
    applyStimulus(1'b1, 1'b1, 8'd20, 4'hC, 1'b1);
    tick();
    checkOutput("clr_busy", busy0, 1);
    checkOutput("clr_v1", rdValid1, 0);
    waitSweep("clr_sweep");
    readCheck("rd20_clr", 8'd20, 4'h0);
    readCheck("rd5_clr", 8'd5, 4'h0);
    readCheck("rd30_ignored", 8'd30, 4'h0);

    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    repeat (10) tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b1);
    tick();
    checkOutput("clr_restart_busy", busy0, 1);
    waitSweep("clr_restart_sweep");

    // Reset arriving mid-sweep must clear outputs without a clock edge.
    applyStimulus(1'b1, 1'b1, 8'd5, 4'h6, 1'b0);
    tick();
    readCheck("rd5_pre_rst", 8'd5, 4'h6);
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'd0, 4'h0, 1'b0);
    repeat (60) tick();
    checkOutput("mid_sweep_busy", busy0, 1);
    checkOutput("mid_sweep_hold", dataOut0, 4'h6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_d0", dataOut0, 0);
    checkOutput("async_rst_d1", dataOut1, 0);
    checkOutput("async_rst_busy", busy0, 1);
    tick();
    rst_n = 1'b1;
    waitSweep("rst_sweep");
    readCheck("rd5_post_rst", 8'd5, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
